// File: rtl/rr_mux_reg_pkg.sv
// Shared definitions for the round-robin register mux: mode encoding and
// the channel-index width helper.
package rr_mux_reg_pkg;

    // Encoding of force_en: 0 selects round-robin, 1 selects fixed channel.
    typedef enum logic {
        ROUND_ROBIN = 1'b0,
        FIXED       = 1'b1
    } mode_e;

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Bundle of the upstream channels, the mode controls and the registered
// downstream port of the round-robin register mux.
interface rr_mux_reg_if
    import rr_mux_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = sel_width(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SELW-1:0]    force_sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    // Environment side: drives channels, mode and downstream ready.
    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_reg_rr_arbiter.sv
// Round-robin priority search: the first requester after ptr (wrapping
// modulo N) wins. Purely combinational.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);
    logic            found;
    logic [SELW-1:0] win_idx;
    int              cand;

    // Scan ptr+1 .. ptr+N (ptr itself last) and keep the first hit.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int off = 1; off <= N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand[SELW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[SELW-1:0];
            end
        end
    end

    assign grant_valid = enable && found;
    assign grant_idx   = win_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant[gi] = grant_valid && (win_idx == SELW'(gi));
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel mux with a single-word registered output. Channels are picked
// round-robin or forced to one index; a new word is accepted whenever the
// output register is empty or being drained in the same cycle.
module rr_mux_reg
    import rr_mux_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_reg_if.slave  bus
);
    localparam int SELW  = sel_width(N);
    localparam int SLOTS = 2 ** SELW;

    mode_e            mode;
    logic             load_en;
    logic             transfer;
    logic             force_in_range;
    logic             fix_any;
    logic             rr_any;
    logic             any_grant;
    logic [N-1:0]     fix_grant;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  sel_idx;
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] ch_data [SLOTS];
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_valid;

    // Unpack channels; index slots beyond N read as zero so the data
    // select never addresses outside the array.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
        if (gi < N) begin : g_real
            assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[gi] = '0;
        end
    end

    assign mode    = mode_e'(bus.force_en);
    assign load_en = !out_valid || bus.out_ready;

    // Fixed mode: only force_sel may win, and only if it is a real channel.
    assign force_in_range = 32'(bus.force_sel) < 32'(N);
    assign fix_any        = force_in_range && bus.in_valid[bus.force_sel];

    for (genvar gi = 0; gi < N; gi++) begin : g_fix
        assign fix_grant[gi] = fix_any && (bus.force_sel == SELW'(gi));
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req         (bus.in_valid),
        .ptr         (ptr),
        .enable      (mode == ROUND_ROBIN),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_any)
    );

    // Pick the grant source for the current mode; switching mode takes
    // effect immediately because this path is combinational.
    always_comb begin
        grant     = '0;
        sel_idx   = '0;
        any_grant = 1'b0;
        if (mode == FIXED) begin
            grant     = fix_grant;
            sel_idx   = bus.force_sel;
            any_grant = fix_any;
        end else begin
            grant     = rr_grant;
            sel_idx   = rr_idx;
            any_grant = rr_any;
        end
    end

    // Ready is withheld during reset so nothing is accepted then.
    assign transfer     = rst_n && load_en && any_grant;
    assign bus.in_ready = transfer ? grant : '0;

    // Output register and round-robin pointer; ptr moves only on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(N - 1);
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[sel_idx];
            out_ch    <= sel_idx;
            ptr       <= sel_idx;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = out_data;
    assign bus.out_ch    = out_ch;
    assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// plus an in-order scoreboard of accepted words.
module tb_rr_mux_reg;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    typedef struct {
        int ch;
        int data;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    rr_mux_reg_if #(.WIDTH(WIDTH), .N(N)) bus ();

    rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: what the output register must hold after the next edge.
    logic  m_known = 1'b0;
    logic  m_valid;
    int    m_data;
    int    m_ch;
    int    m_ptr;
    int    n_xfer = 0;
    int    n_drain = 0;
    int    n_drop = 0;
    word_t sb[$];

    // Per-cycle compare and model advance, sampled mid-cycle.
    always @(negedge clk) begin : model
        int    g;
        int    c;
        word_t w;
        g = -1;
        if (m_known) begin
            check("out_valid", int'(bus.out_valid), int'(m_valid));
            check("out_data", int'(bus.out_data), m_data);
            check("out_ch", int'(bus.out_ch), m_ch);
            if (rst_n && (!m_valid || bus.out_ready)) begin
                if (bus.force_en) begin
                    if (int'(bus.force_sel) < N && bus.in_valid[bus.force_sel])
                        g = int'(bus.force_sel);
                end else begin
                    for (int off = 1; off <= N; off++) begin
                        c = (m_ptr + off) % N;
                        if (g < 0 && bus.in_valid[2'(c)]) g = c;
                    end
                end
            end
            check("in_ready", int'(bus.in_ready), (g >= 0) ? (1 << g) : 0);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    check("sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        w = sb.pop_front();
                        check("sb_ch", int'(bus.out_ch), w.ch);
                        check("sb_data", int'(bus.out_data), w.data);
                    end
                    n_drain++;
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.in_valid[i] && bus.in_ready[i]) begin
                        w.ch   = i;
                        w.data = int'(bus.in_data[i*WIDTH +: WIDTH]);
                        sb.push_back(w);
                        n_xfer++;
                    end
                end
            end
        end
        if (!rst_n) begin
            n_drop  += sb.size();
            sb.delete();
            m_known <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= 0;
            m_ch    <= 0;
            m_ptr   <= N - 1;
        end else if (m_known) begin
            if (g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= int'(bus.in_data[g*WIDTH +: WIDTH]);
                m_ch    <= g;
                m_ptr   <= g;
            end else if (bus.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int exp_ch [5];
        int exp_dt [5];
        exp_ch = '{0, 1, 2, 3, 0};
        exp_dt = '{'h11, 'h22, 'h33, 'h44, 'h11};

        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.force_en  = 1'b0;
        bus.force_sel = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_ch", int'(bus.out_ch), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        bus.in_valid  = 4'hF;
        bus.in_data   = 32'h44332211;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 0);

        // Round-robin over all channels from reset.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_seq_ch", int'(bus.out_ch), exp_ch[i]);
            check("rr_seq_data", int'(bus.out_data), exp_dt[i]);
        end

        // Sparse requests on 0 and 2 with ptr at 0.
        bus.in_valid = 4'b0101;
        tick(); check("sparse_ch_a", int'(bus.out_ch), 2);
        tick(); check("sparse_ch_b", int'(bus.out_ch), 0);
        tick(); check("sparse_ch_c", int'(bus.out_ch), 2);

        // Backpressure on a ch1 word.
        bus.in_valid = 4'b0010;
        tick(); check("bp_load_ch", int'(bus.out_ch), 1);
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check("bp_in_ready", int'(bus.in_ready), 0);
            tick();
            check("bp_hold_ch", int'(bus.out_ch), 1);
            check("bp_hold_data", int'(bus.out_data), 'h22);
            check("bp_hold_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        #1; check("bp_release_ready", int'(bus.in_ready), 4'b0100);
        tick(); check("bp_next_ch", int'(bus.out_ch), 2);

        // Fixed mode on channel 3.
        bus.force_en  = 1'b1;
        bus.force_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fix_ch", int'(bus.out_ch), 3);
            check("fix_data", int'(bus.out_data), 'h44);
        end
        bus.in_valid = 4'b0111;
        #1; check("fix_idle_ready", int'(bus.in_ready), 0);
        tick();
        check("fix_drain_valid", int'(bus.out_valid), 0);
        check("fix_drain_ch", int'(bus.out_ch), 3);

        // Reset while a word is stalled.
        bus.force_en  = 1'b0;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b0;
        tick(); check("pre_rst_ch", int'(bus.out_ch), 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_ch", int'(bus.out_ch), 0);
        #1; check("mid_rst_ready", int'(bus.in_ready), 0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_ch", int'(bus.out_ch), 0);
        check("post_rst_data", int'(bus.out_data), 'h11);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.force_en  = ($urandom_range(0, 7) == 0);
            bus.force_sel = 2'($urandom);
            tick();
        end

        // Drain and reconcile.
        rst_n         = 1'b1;
        bus.in_valid  = '0;
        bus.force_en  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("final_sb_empty", sb.size(), 0);
        check("final_accounting", n_xfer, n_drain + n_drop);
        check("traffic_volume", int'(n_xfer > 300), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_reg.md
RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL have derived local parameter SELW = clog2(N), channel-index width.
REQ-004 SHALL use one clock and synchronous, active-low reset; ports are clk and rst_n.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready, combinational.
REQ-010 force_en  input  1  1 = fixed-select mode, 0 = round-robin mode.
REQ-011 force_sel  input  SELW  channel selected when force_en=1.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_ch  output  SELW  registered index of the channel that supplied out_data.
REQ-014 out_valid  output  1  registered output valid.
REQ-015 out_ready  input  1  downstream ready.

Function
REQ-016 load_en SHALL equal (!out_valid || out_ready), so the output register holds exactly one word.
REQ-017 An input transfer on channel i SHALL occur when in_valid[i] && in_ready[i].
REQ-018 in_ready[i] SHALL be 1 only when load_en=1 and channel i holds the grant; at most one bit of in_ready SHALL be high.
REQ-019 Round-robin mode: grant SHALL go to the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo N, where ptr is the last granted channel.
REQ-020 Fixed mode: grant SHALL go to channel force_sel only, and only if in_valid[force_sel]=1; other channels SHALL see in_ready=0.
REQ-021 force_sel >= N SHALL grant no channel.
REQ-022 ptr SHALL update to the granted index only on a transfer, in both modes; if no transfer occurs, ptr SHALL hold.
REQ-023 On a transfer, out_data, out_ch and out_valid=1 SHALL load on the next rising edge, giving 1-cycle latency.
REQ-024 When out_valid && out_ready and no input transfer occurs, out_valid SHALL clear on the next edge; out_data and out_ch SHALL hold.
REQ-025 Simultaneous output drain and input transfer SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-026 While out_valid && !out_ready, out_data and out_ch SHALL remain stable and in_ready SHALL be all 0.
REQ-027 Mode change via force_en SHALL take effect in the same cycle; ptr is unaffected by the change itself.
REQ-028 With no in_valid set, the block SHALL idle and no state SHALL change except the out_valid drain.

Reset
REQ-029 When rst_n=0 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=N-1, so channel 0 has first priority after reset.
REQ-030 While rst_n=0, in_ready SHALL be all 0; a word pending at reset SHALL be discarded.

Structure
REQ-031 A shared package SHALL hold the clog2-based SELW helper and the mode encoding constants FIXED and ROUND_ROBIN.
REQ-032 The round-robin priority search SHALL be one sub-module, rr_arbiter (inputs: req[N], ptr, enable; outputs: one-hot grant[N], grant index).
REQ-033 The implementation SHALL be synthesizable with no latches and no internal clock or reset gating.

Verification (WIDTH=8, N=4)
REQ-034 Reset then all in_valid=1, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1, force_en=0 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 11,22,33,44,11.
REQ-035 Only in_valid[2]=1 and in_valid[0]=1 with ptr=0 -> grant ch2, then ch0, then ch2.
REQ-036 out_ready=0 for 3 cycles after a word with out_ch=1 loads -> out_data and out_ch hold, in_ready=0, no channel loses data; out_ready=1 -> next grant is ch2.
REQ-037 force_en=1, force_sel=3, all valid -> every transfer from ch3; force_sel=3 with in_valid[3]=0 -> out_valid drops after the drain, in_ready=0.
REQ-038 rst_n=0 asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_ch=0; first grant after release is ch0.
REQ-039 Random valid/ready traffic for 1000 cycles -> a scoreboard matches every input transfer to exactly one output word, in order, with no loss or duplication.
